hex_entry_input: RTL and testbench

- Board-side user input path for the Basys target; the input counterpart of the seven-segment display path.
- Synchronizes and debounces the five push buttons and converts presses into one-cycle pulses.
- Assembles a 32-bit hex value nibble-by-nibble from sw[3:0].
- Hands the value to the core over a valid/ready handshake, tagged with a destination register select (R0/R1).
- entry_value is exported live so the display path can echo the value being typed.

---
 rtl/hex_entry_input.sv | 174 +++++++++++++++++
 tb/tb_hex_entry_input.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry_input.sv
// Button/switch hex entry for the Basys board: debounced push buttons build a 32-bit value
// nibble by nibble and hand it to the core over valid/ready. Optional: HEX_ENTRY_AUTOREPEAT_EN.
module hex_entry_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  btn_raw,
    input  logic [3:0]  sw,
    input  logic        data_ready,
    output logic [31:0] entry_value,
    output logic [3:0]  entry_count,
    output logic        dest_sel,
    output logic [31:0] data_out,
    output logic        data_valid
);

    localparam logic [0:0] EDIT = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_L = 3;
    localparam int BTN_R = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES - 1) >= (2 ** CNT_W)
        || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("hex_entry_input: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0][CNT_W-1:0]       cnt_q;
    logic [4:0]                  st_q;
    logic [4:0]                  st_dly_q;
    logic [4:0]                  sync_bit;
    logic [4:0]                  pulse;
    logic                        shift_req;

    logic [0:0]  state_q,  state_d;
    logic [31:0] value_q,  value_d;
    logic [3:0]  count_q,  count_d;
    logic        dest_q,   dest_d;
    logic [31:0] dout_q,   dout_d;
    logic        valid_q,  valid_d;

    // NOTE: every clocked block uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // A change is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            st_q     <= '0;
            st_dly_q <= '0;
        end else begin
            st_dly_q <= st_q;
            for (int b = 0; b < 5; b++) begin
                if (sync_bit[b] == st_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CNT_MAX) begin
                    st_q[b]  <= sync_bit[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign pulse = st_q & ~st_dly_q;

`ifdef HEX_ENTRY_AUTOREPEAT_EN
    logic [31:0] hold_q;
    logic        rep_pulse;

    // hold_q walks 0..DELAY, then cycles DELAY..DELAY+PERIOD-1; each visit to DELAY injects a shift.
    always_ff @(posedge clk) begin
        if (reset || !st_q[BTN_U] || state_q != EDIT) begin
            hold_q <= '0;
        end else if (hold_q == 32'(REPEAT_DELAY + REPEAT_PERIOD - 1)) begin
            hold_q <= 32'(REPEAT_DELAY);
        end else begin
            hold_q <= hold_q + 32'd1;
        end
    end

    assign rep_pulse = st_q[BTN_U] && (state_q == EDIT) && (hold_q == 32'(REPEAT_DELAY));
    assign shift_req = pulse[BTN_U] | rep_pulse;
`else
    assign shift_req = pulse[BTN_U];
`endif

    // NOTE: every always_comb output takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
        dest_d  = dest_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        case (state_q)
            EDIT: begin
                if (pulse[BTN_L]) begin
                    value_d = '0;
                    count_d = '0;
                end else if (pulse[BTN_C]) begin
                    dout_d  = value_q;
                    valid_d = 1'b1;
                    state_d = PEND;
                end else if (pulse[BTN_D]) begin
                    value_d = value_q >> 4;
                    count_d = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;
                end else if (shift_req) begin
                    value_d = {value_q[27:0], sw};
                    count_d = (count_q == 4'd8) ? 4'd8 : count_q + 4'd1;
                end else if (pulse[BTN_R]) begin
                    dest_d = ~dest_q;
                end
            end
            default: begin
                if (pulse[BTN_L]) begin
                    value_d = '0;
                    count_d = '0;
                end
                if (valid_q && data_ready) begin
                    valid_d = 1'b0;
                    value_d = '0;
                    count_d = '0;
                    state_d = EDIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EDIT;
            value_q <= '0;
            count_q <= '0;
            dest_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign entry_value = value_q;
    assign entry_count = count_q;
    assign dest_sel    = dest_q;
    assign data_out    = dout_q;
    assign data_valid  = valid_q;

endmodule

// File: tb/tb_hex_entry_input.sv
// Bench for hex_entry_input: event-level reference model compared every cycle, plus
// hand-computed expectations from the directed scenarios.
module tb_hex_entry_input;

    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  btn_raw;
    logic [3:0]  sw;
    logic        data_ready;
    logic [31:0] entry_value;
    logic [3:0]  entry_count;
    logic        dest_sel;
    logic [31:0] data_out;
    logic        data_valid;

    int n_checks = 0;
    int n_errors = 0;

    hex_entry_input #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .sw         (sw),
        .data_ready (data_ready),
        .entry_value(entry_value),
        .entry_count(entry_count),
        .dest_sel   (dest_sel),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw buttons seen SYNC cycles late; a button is accepted once it has
    // disagreed with its accepted level for DEB consecutive cycles, and a press acts one edge later.
    logic [4:0]  m_hist [SYNC];
    logic [4:0]  m_stable = '0;
    int          m_run [5];
    logic [4:0]  m_press = '0;
    logic [31:0] m_value = '0;
    int          m_count = 0;
    logic        m_dest = 1'b0;
    logic [31:0] m_dout = '0;
    logic        m_valid = 1'b0;
    logic        m_pend = 1'b0;
    logic        started = 1'b0;

    always @(posedge clk) begin
        logic [4:0] s;
        logic [4:0] new_press;
        if (reset) begin
            started  = 1'b1;
            for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
            for (int b = 0; b < 5; b++) m_run[b] = 0;
            m_stable = '0;
            m_press  = '0;
            m_value  = '0;
            m_count  = 0;
            m_dest   = 1'b0;
            m_dout   = '0;
            m_valid  = 1'b0;
            m_pend   = 1'b0;
        end else if (started) begin
            if (!m_pend) begin
                if (m_press[3]) begin
                    m_value = 0; m_count = 0;
                end else if (m_press[0]) begin
                    m_dout = m_value; m_valid = 1'b1; m_pend = 1'b1;
                end else if (m_press[2]) begin
                    m_value = m_value / 16;
                    if (m_count > 0) m_count--;
                end else if (m_press[1]) begin
                    m_value = (m_value * 16) + 32'(sw);
                    if (m_count < 8) m_count++;
                end else if (m_press[4]) begin
                    m_dest = !m_dest;
                end
            end else begin
                if (m_press[3]) begin
                    m_value = 0; m_count = 0;
                end
                if (data_ready) begin
                    m_valid = 1'b0; m_value = 0; m_count = 0; m_pend = 1'b0;
                end
            end
            s = m_hist[SYNC-1];
            new_press = '0;
            for (int b = 0; b < 5; b++) begin
                if (s[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_stable[b]  = s[b];
                        m_run[b]     = 0;
                        new_press[b] = s[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = btn_raw;
            m_press = new_press;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("entry_value", entry_value, m_value);
            check("entry_count", 32'(entry_count), 32'(m_count));
            check("dest_sel", 32'(dest_sel), 32'(m_dest));
            check("data_out", data_out, m_dout);
            check("data_valid", 32'(data_valid), 32'(m_valid));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold long enough for the press to be accepted and acted on, then let the release settle.
    task automatic press(input logic [4:0] mask);
        btn_raw = mask;
        tick(DEB + SYNC + 4);
        btn_raw = '0;
        tick(DEB + SYNC + 4);
    endtask

    task automatic shift_nib(input logic [3:0] n);
        sw = n;
        press(5'b00010);
    endtask

    initial begin
        reset = 1'b1; btn_raw = '0; sw = '0; data_ready = 1'b0;
        tick(2);
        check("rst_value", entry_value, 32'h0);
        check("rst_count", 32'(entry_count), 32'h0);
        check("rst_dest", 32'(dest_sel), 32'h0);
        check("rst_dout", data_out, 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        reset = 1'b0;
        tick(2);

        // 1: bouncing U is rejected, the final stable press shifts once
        sw = 4'hA;
        for (int i = 0; i < 10; i++) begin
            btn_raw = 5'b00010; tick(2);
            btn_raw = 5'b00000; tick(2);
        end
        btn_raw = 5'b00010; tick(10);
        btn_raw = '0; tick(10);
        check("t1_value", entry_value, 32'h0000000A);
        check("t1_count", 32'(entry_count), 32'd1);

        // 2: commit held while not ready, then handshake
        press(5'b01000);
        shift_nib(4'h1); shift_nib(4'h2); shift_nib(4'h3); shift_nib(4'h4);
        press(5'b00001);
        for (int i = 0; i < 10; i++) begin
            check("t2_valid_hold", 32'(data_valid), 32'd1);
            tick(1);
        end
        check("t2_dout", data_out, 32'h00001234);
        check("t2_dest", 32'(dest_sel), 32'd0);
        data_ready = 1'b1;
        tick(1);
        check("t2_valid_drop", 32'(data_valid), 32'd0);
        check("t2_value_clr", entry_value, 32'h0);
        check("t2_count_clr", 32'(entry_count), 32'd0);
        data_ready = 1'b0;
        tick(2);

        // 3: overflow past 8 nibbles, then backspace
        for (int n = 1; n <= 9; n++) shift_nib(4'(n));
        check("t3_value", entry_value, 32'h23456789);
        check("t3_count", 32'(entry_count), 32'd8);
        press(5'b00100);
        check("t3_bs_value", entry_value, 32'h02345678);
        check("t3_bs_count", 32'(entry_count), 32'd7);

        // 4: toggle destination, commit, then presses in PEND are ignored
        press(5'b01000);
        press(5'b10000);
        shift_nib(4'hF);
        press(5'b00001);
        check("t4_dest", 32'(dest_sel), 32'd1);
        check("t4_dout", data_out, 32'h0000000F);
        sw = 4'h3;
        press(5'b00010); press(5'b00100); press(5'b10000);
        check("t4_pend_value", entry_value, 32'h0000000F);
        check("t4_pend_dest", 32'(dest_sel), 32'd1);
        check("t4_pend_dout", data_out, 32'h0000000F);
        check("t4_pend_valid", 32'(data_valid), 32'd1);

        // 5: reset while pending aborts the transfer
        reset = 1'b1; tick(1); reset = 1'b0;
        check("t5_valid", 32'(data_valid), 32'd0);
        check("t5_dout", data_out, 32'h0);
        check("t5_value", entry_value, 32'h0);
        check("t5_dest", 32'(dest_sel), 32'd0);
        shift_nib(4'h5);
        check("t5_edit", entry_value, 32'h00000005);

        // 6: clear and shift accepted together, clear wins
        press(5'b01000);
        shift_nib(4'h1); shift_nib(4'h2);
        check("t6_pre", entry_value, 32'h00000012);
        sw = 4'h7;
        press(5'b01010);
        check("t6_value", entry_value, 32'h0);
        check("t6_count", 32'(entry_count), 32'd0);

        // commit with nothing entered sends zero
        shift_nib(4'h9);
        press(5'b01000);
        press(5'b00001);
        check("t7_valid", 32'(data_valid), 32'd1);
        check("t7_dout", data_out, 32'h0);
        data_ready = 1'b1; tick(1); data_ready = 1'b0;
        check("t7_done", 32'(data_valid), 32'd0);

        // clear during PEND wipes the entry but keeps the transfer alive
        shift_nib(4'h7);
        press(5'b00001);
        press(5'b01000);
        check("t8_value", entry_value, 32'h0);
        check("t8_valid", 32'(data_valid), 32'd1);
        check("t8_dout", data_out, 32'h00000007);
        data_ready = 1'b1; tick(1); data_ready = 1'b0;
        check("t8_done", 32'(data_valid), 32'd0);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
